// File: rtl/qspi_arb_pkg.sv
// rtl/qspi_arb_pkg.sv - shared types, idle pad values and counter sizing for the QSPI flash arbiter
//
// Contents:
//   arb_state_t   - arbiter FSM state encoding (IDLE, OWN0, OWN1, GUARD)
//   CS_IDLE       - chip-select level driven while nobody owns the pins
//   DQ_IDLE_O     - pad data value driven while nobody owns the pins
//   DQ_IDLE_I     - data returned to a non-owner (matches the board pull-ups)
//   cnt_width()   - bits needed to hold a counter value 0..max_val
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_GUARD = 2'd3
    } arb_state_t;

    localparam logic       CS_IDLE   = 1'b1;
    localparam logic [3:0] DQ_IDLE_O = 4'h0;
    localparam logic [3:0] DQ_IDLE_I = 4'hF;

    localparam int GUARD_CYCLES_DEF = 4;
    localparam int HOLD_MAX_DEF     = 1024;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int GUARD_W_DEF = cnt_width(GUARD_CYCLES_DEF);
    localparam int HOLD_W_DEF  = cnt_width(HOLD_MAX_DEF);

endpackage

// File: rtl/qspi_pin_mux.sv
// rtl/qspi_pin_mux.sv - combinational 2:1 pad mux and data return path for two QSPI masters
//
// Ports:
//   sel          - owner select (0 = requester 0, 1 = requester 1)
//   force_idle   - drive idle pad values and idle return data to both masters
//   m0_*, m1_*   - per-master sck, cs_n, dq_o, dq_oe in; dq_i out
//   pad_*        - pad sck, cs_n, dq_o, dq_oe out; pad_dq_i in
module qspi_pin_mux
    import qspi_arb_pkg::*;
(
    input  logic       sel,
    input  logic       force_idle,
    input  logic       m0_sck,
    input  logic       m0_cs_n,
    input  logic [3:0] m0_dq_o,
    input  logic [3:0] m0_dq_oe,
    output logic [3:0] m0_dq_i,
    input  logic       m1_sck,
    input  logic       m1_cs_n,
    input  logic [3:0] m1_dq_o,
    input  logic [3:0] m1_dq_oe,
    output logic [3:0] m1_dq_i,
    output logic       pad_sck,
    output logic       pad_cs_n,
    output logic [3:0] pad_dq_o,
    output logic [3:0] pad_dq_oe,
    input  logic [3:0] pad_dq_i
);

    always_comb begin
        pad_sck   = 1'b0;
        pad_cs_n  = CS_IDLE;
        pad_dq_o  = DQ_IDLE_O;
        pad_dq_oe = 4'h0;
        m0_dq_i   = DQ_IDLE_I;
        m1_dq_i   = DQ_IDLE_I;
        if (!force_idle) begin
            if (sel) begin
                pad_sck   = m1_sck;
                pad_cs_n  = m1_cs_n;
                pad_dq_o  = m1_dq_o;
                pad_dq_oe = m1_dq_oe;
                m1_dq_i   = pad_dq_i;
            end else begin
                pad_sck   = m0_sck;
                pad_cs_n  = m0_cs_n;
                pad_dq_o  = m0_dq_o;
                pad_dq_oe = m0_dq_oe;
                m0_dq_i   = pad_dq_i;
            end
        end
    end

endmodule

// File: rtl/qspi_flash_arbiter.sv
// rtl/qspi_flash_arbiter.sv - two-master QSPI flash pin arbiter with guard gap and idle-hold preemption
//
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   m0_req / m1_req       - requester wants the flash
//   m0_gnt / m1_gnt       - requester owns the pins (registered)
//   mX_sck, mX_cs_n       - requester serial clock and chip select
//   mX_dq_o, mX_dq_oe     - requester data out and output enables
//   mX_dq_i               - data returned to requester (4'hF when not owner)
//   pad_*                 - flash pins toward IOBUF / STARTUPE2
//   busy                  - pins owned or guard gap running
module qspi_flash_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
    parameter int HOLD_MAX     = HOLD_MAX_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       m0_req,
    output logic       m0_gnt,
    input  logic       m0_sck,
    input  logic       m0_cs_n,
    input  logic [3:0] m0_dq_o,
    input  logic [3:0] m0_dq_oe,
    output logic [3:0] m0_dq_i,
    input  logic       m1_req,
    output logic       m1_gnt,
    input  logic       m1_sck,
    input  logic       m1_cs_n,
    input  logic [3:0] m1_dq_o,
    input  logic [3:0] m1_dq_oe,
    output logic [3:0] m1_dq_i,
    output logic       pad_sck,
    output logic       pad_cs_n,
    output logic [3:0] pad_dq_o,
    output logic [3:0] pad_dq_oe,
    input  logic [3:0] pad_dq_i,
    output logic       busy
);

    localparam int GW = cnt_width(GUARD_CYCLES);
    localparam int HW = cnt_width(HOLD_MAX);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LIM   = HW'(HOLD_MAX);

    arb_state_t     state;
    logic           last_owner;
    logic [GW-1:0]  guard_cnt;
    logic [HW-1:0]  idle_cnt;

    logic own_cs_n;
    logic own_req;
    logic other_req;
    logic hold_hit;
    logic release_own;

    // Owner-relative view so OWN0 and OWN1 share one exit rule.
    always_comb begin
        own_cs_n    = (state == ST_OWN1) ? m1_cs_n : m0_cs_n;
        own_req     = (state == ST_OWN1) ? m1_req  : m0_req;
        other_req   = (state == ST_OWN1) ? m0_req  : m1_req;
        hold_hit    = (HOLD_MAX != 0) && other_req && (idle_cnt == HOLD_LIM);
        // A live transaction (cs_n low) always blocks release.
        release_own = own_cs_n && (!own_req || hold_hit);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            busy       <= 1'b0;
            last_owner <= 1'b1;
            guard_cnt  <= '0;
            idle_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    guard_cnt <= '0;
                    idle_cnt  <= '0;
                    // Round robin on a tie: the side that did not own last wins.
                    if (m0_req && (!m1_req || last_owner)) begin
                        state  <= ST_OWN0;
                        m0_gnt <= 1'b1;
                        busy   <= 1'b1;
                    end else if (m1_req) begin
                        state  <= ST_OWN1;
                        m1_gnt <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (release_own) begin
                        state      <= ST_GUARD;
                        m0_gnt     <= 1'b0;
                        m1_gnt     <= 1'b0;
                        last_owner <= (state == ST_OWN1);
                        idle_cnt   <= '0;
                        guard_cnt  <= '0;
                    end else if (!own_cs_n || !other_req) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != HOLD_LIM) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        guard_cnt <= '0;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    m0_gnt <= 1'b0;
                    m1_gnt <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Pads depend only on registered state, so no latency is added on any pin.
    qspi_pin_mux u_pin_mux (
        .sel        (state == ST_OWN1),
        .force_idle (!((state == ST_OWN0) || (state == ST_OWN1))),
        .m0_sck     (m0_sck),
        .m0_cs_n    (m0_cs_n),
        .m0_dq_o    (m0_dq_o),
        .m0_dq_oe   (m0_dq_oe),
        .m0_dq_i    (m0_dq_i),
        .m1_sck     (m1_sck),
        .m1_cs_n    (m1_cs_n),
        .m1_dq_o    (m1_dq_o),
        .m1_dq_oe   (m1_dq_oe),
        .m1_dq_i    (m1_dq_i),
        .pad_sck    (pad_sck),
        .pad_cs_n   (pad_cs_n),
        .pad_dq_o   (pad_dq_o),
        .pad_dq_oe  (pad_dq_oe),
        .pad_dq_i   (pad_dq_i)
    );

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// tb/tb_qspi_flash_arbiter.sv - scoreboard bench for qspi_flash_arbiter with a behavioural ownership model
module tb_qspi_flash_arbiter;

    localparam int G  = 4;
    localparam int HM = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [1:0]      req_v;
    logic [1:0]      csn_v;
    logic [1:0]      sck_v;
    logic [1:0][3:0] dqo_v;
    logic [1:0][3:0] dqoe_v;
    logic [3:0]      pdqi;

    logic       m0_gnt, m1_gnt, busy;
    logic [3:0] m0_dq_i, m1_dq_i;
    logic       pad_sck, pad_cs_n;
    logic [3:0] pad_dq_o, pad_dq_oe;

    qspi_flash_arbiter #(.GUARD_CYCLES(G), .HOLD_MAX(HM)) dut (
        .clock     (clk),
        .reset     (reset),
        .m0_req    (req_v[0]),
        .m0_gnt    (m0_gnt),
        .m0_sck    (sck_v[0]),
        .m0_cs_n   (csn_v[0]),
        .m0_dq_o   (dqo_v[0]),
        .m0_dq_oe  (dqoe_v[0]),
        .m0_dq_i   (m0_dq_i),
        .m1_req    (req_v[1]),
        .m1_gnt    (m1_gnt),
        .m1_sck    (sck_v[1]),
        .m1_cs_n   (csn_v[1]),
        .m1_dq_o   (dqo_v[1]),
        .m1_dq_oe  (dqoe_v[1]),
        .m1_dq_i   (m1_dq_i),
        .pad_sck   (pad_sck),
        .pad_cs_n  (pad_cs_n),
        .pad_dq_o  (pad_dq_o),
        .pad_dq_oe (pad_dq_oe),
        .pad_dq_i  (pdqi),
        .busy      (busy)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: who owns the pins, guard cycles still to run,
    // cycles the owner has sat idle under contention, and the last owner.
    int m_owner = -1;
    int m_guard = 0;
    int m_hold  = 0;
    int m_last  = 1;

    task automatic model_step();
        logic rq, oreq, ocs;
        if (reset) begin
            m_owner = -1; m_guard = 0; m_hold = 0; m_last = 1;
        end else if (m_guard > 0) begin
            m_guard--;
        end else if (m_owner < 0) begin
            if (req_v == 2'b11) m_owner = 1 - m_last;
            else if (req_v[0])  m_owner = 0;
            else if (req_v[1])  m_owner = 1;
        end else begin
            rq   = req_v[m_owner];
            oreq = req_v[1 - m_owner];
            ocs  = csn_v[m_owner];
            if (ocs && (!rq || (oreq && m_hold >= HM))) begin
                m_last = m_owner; m_owner = -1; m_guard = G; m_hold = 0;
            end else if (!ocs || !oreq) begin
                m_hold = 0;
            end else if (m_hold < HM) begin
                m_hold++;
            end
        end
    endtask

    function automatic logic [20:0] model_out();
        logic g0, g1, bz, sck, cs;
        logic [3:0] o, oe, i0, i1;
        g0 = (m_owner == 0); g1 = (m_owner == 1);
        bz = (m_owner >= 0) || (m_guard > 0);
        sck = 1'b0; cs = 1'b1; o = 4'h0; oe = 4'h0; i0 = 4'hF; i1 = 4'hF;
        if (m_owner >= 0) begin
            sck = sck_v[m_owner]; cs = csn_v[m_owner];
            o = dqo_v[m_owner]; oe = dqoe_v[m_owner];
            if (g0) i0 = pdqi; else i1 = pdqi;
        end
        return {g0, g1, bz, sck, cs, o, oe, i0, i1};
    endfunction

    logic [20:0] exp_q[$];

    // Inputs are set just after a rising edge; the expected outputs for that
    // cycle are queued here and the monitor checks them on the falling edge.
    task automatic cycle();
        pdqi = 4'($urandom);
        exp_q.push_back(model_out());
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin : monitor
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("outputs@%0t", $time),
                      32'({m0_gnt, m1_gnt, busy, pad_sck, pad_cs_n, pad_dq_o,
                           pad_dq_oe, m0_dq_i, m1_dq_i}),
                      32'(e));
            end
        end
    end

    task automatic set_idle(input int i);
        csn_v[i] = 1'b1; sck_v[i] = 1'b0; dqo_v[i] = 4'h0; dqoe_v[i] = 4'h0;
    endtask

    task automatic run_until(input int which, input logic val, input int bound, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (((which == 0) ? m0_gnt : m1_gnt) !== val && n < bound);
    endtask

    task automatic agent_step();
        for (int i = 0; i < 2; i++) begin
            if (m_owner == i) begin
                if (!csn_v[i]) begin
                    sck_v[i] = ~sck_v[i];
                    dqo_v[i] = 4'($urandom); dqoe_v[i] = 4'($urandom);
                    if ($urandom_range(7) == 0) begin csn_v[i] = 1'b1; sck_v[i] = 1'b0; end
                end else if ($urandom_range(3) == 0) begin
                    csn_v[i] = 1'b0;
                end
                if ($urandom_range(23) == 0) req_v[i] = 1'b0;
            end else begin
                if (!req_v[i] && $urandom_range(7) == 0) req_v[i] = 1'b1;
                // Non-owner noise on cs/sck/dq must never reach the pads.
                csn_v[i] = 1'($urandom); sck_v[i] = 1'($urandom);
                dqo_v[i] = 4'($urandom); dqoe_v[i] = 4'($urandom);
            end
        end
        reset = ($urandom_range(499) == 0);
    endtask

    initial begin : stim
        int n;
        int held;
        int drops;
        reset = 1'b1; req_v = 2'b00; pdqi = 4'h0;
        set_idle(0); set_idle(1);
        @(posedge clk); #1;
        repeat (3) cycle();
        check("reset m0_gnt", 32'(m0_gnt), 0);
        check("reset m1_gnt", 32'(m1_gnt), 0);
        check("reset busy", 32'(busy), 0);
        check("reset pad_cs_n", 32'(pad_cs_n), 1);
        reset = 1'b0;
        cycle();

        // Requester 0 alone, with requester 1 toggling its pins ungranted.
        req_v[0] = 1'b1;
        cycle();
        check("m0 gnt latency", 32'(m0_gnt), 1);
        csn_v[0] = 1'b0;
        repeat (12) begin
            sck_v[0] = ~sck_v[0]; dqo_v[0] = 4'($urandom); dqoe_v[0] = 4'($urandom);
            csn_v[1] = 1'($urandom); sck_v[1] = 1'($urandom); dqo_v[1] = 4'($urandom);
            cycle();
        end
        set_idle(0); set_idle(1);
        cycle();
        req_v[0] = 1'b0;
        repeat (8) cycle();
        check("idle after release busy", 32'(busy), 0);

        // Simultaneous requests after reset: requester 0 first, then guard gap.
        reset = 1'b1; cycle(); reset = 1'b0;
        req_v = 2'b11;
        cycle();
        check("tie m0_gnt", 32'(m0_gnt), 1);
        check("tie m1_gnt", 32'(m1_gnt), 0);
        repeat (3) cycle();
        req_v[0] = 1'b0;
        run_until(1, 1'b1, 20, n);
        check("handover gap", 32'(n), 32'(G + 2));

        // Requester 1 releases; requester 0 drops req mid-transaction.
        req_v[1] = 1'b0; req_v[0] = 1'b1;
        run_until(0, 1'b1, 20, n);
        check("m0 regrant gap", 32'(n), 32'(G + 2));
        csn_v[0] = 1'b0; req_v[0] = 1'b0; held = 1;
        repeat (20) begin
            sck_v[0] = ~sck_v[0]; dqo_v[0] = 4'($urandom);
            cycle();
            if (m0_gnt !== 1'b1) held = 0;
        end
        check("gnt held while cs low", 32'(held), 1);
        set_idle(0);
        cycle();
        check("release after cs rise gnt", 32'(m0_gnt), 0);
        check("release after cs rise busy", 32'(busy), 1);
        repeat (G + 2) cycle();

        // Idle-hold preemption.
        req_v[0] = 1'b1;
        run_until(0, 1'b1, 10, n);
        repeat (3) cycle();
        req_v[1] = 1'b1;
        run_until(0, 1'b0, 40, n);
        check("preempt after hold", 32'(n), 32'(HM + 1));
        run_until(1, 1'b1, 20, n);
        check("preempt handover", 32'(n), 32'(G + 1));
        drops = 0;
        repeat (6) begin
            csn_v[1] = 1'b0; cycle();
            if (m1_gnt !== 1'b1) drops++;
            csn_v[1] = 1'b1;
            repeat (9) begin
                cycle();
                if (m1_gnt !== 1'b1) drops++;
            end
        end
        check("no preempt with cs pulses", 32'(drops), 0);

        // Reset in the middle of a requester 1 transfer.
        csn_v[1] = 1'b0; dqoe_v[1] = 4'hF; sck_v[1] = 1'b1;
        cycle();
        check("own1 before reset", 32'(m1_gnt), 1);
        reset = 1'b1;
        cycle();
        check("reset pad_cs_n", 32'(pad_cs_n), 1);
        check("reset pad_dq_oe", 32'(pad_dq_oe), 0);
        check("reset gnts", 32'({m0_gnt, m1_gnt}), 0);
        check("reset busy mid", 32'(busy), 0);
        reset = 1'b0; req_v = 2'b00; set_idle(0); set_idle(1);
        repeat (2) cycle();

        repeat (3000) begin
            agent_step();
            cycle();
        end

        reset = 1'b0;
        @(negedge clk); #1;
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
